// File: rtl/speicher_pkg.sv
// rtl/speicher_pkg.sv - shared types and constants for the memory controller
package speicher_pkg;

  typedef enum logic [1:0] {
    LEER    = 2'd0,
    ZUGRIFF = 2'd1,
    WARTEN  = 2'd2,
    FERTIG  = 2'd3
  } zustand_t;

  localparam int IO_BIT           = 31;
  localparam int DEFAULT_WORDSIZE = 32;
  localparam int DEFAULT_WORDS    = 256;

endpackage

// File: rtl/speicher_dekoder.sv
// rtl/speicher_dekoder.sv - combinational IO / RAM / out-of-range address decode
// Range check only exists when BEREICHSPRUEFUNG_EN is defined; otherwise high bits alias.
module speicher_dekoder
  import speicher_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic [31:0] adresse,
  output logic        ist_io,
  output logic        ist_ram,
  output logic        ausserhalb
);

  always_comb begin
    ist_io  = adresse[IO_BIT];
    ist_ram = !adresse[IO_BIT];
  end

`ifdef BEREICHSPRUEFUNG_EN
  logic unused_adresse_bits;
  assign unused_adresse_bits = ^adresse[AW-1:0];
  assign ausserhalb = !adresse[IO_BIT] && (adresse[IO_BIT-1:AW] != '0);
`else
  logic unused_adresse_bits;
  assign unused_adresse_bits = ^adresse[IO_BIT-1:0];
  assign ausserhalb = 1'b0;
`endif

endmodule

// File: rtl/speicher_steuerung.sv
// rtl/speicher_steuerung.sv - CPU-to-RAM/IO access controller, RAM lives outside this block
// Optional address range check enabled by BEREICHSPRUEFUNG_EN.
module speicher_steuerung
  import speicher_pkg::*;
#(
  parameter int  WORDSIZE = DEFAULT_WORDSIZE,
  parameter int  WORDS    = DEFAULT_WORDS,
  localparam int AW       = $clog2(WORDS)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Anfrage,
  input  logic                SchreibenAn,
  input  logic [31:0]         Adresse,
  input  logic [WORDSIZE-1:0] DatenRein,
  output logic                Bereit,
  output logic                Fertig,
  output logic [WORDSIZE-1:0] DatenRaus,
  output logic [WORDSIZE-1:0] Ausgabe,
  output logic                Fehler,
  output logic                RamSchreibenAn,
  output logic [AW-1:0]       RamAdresse,
  output logic [WORDSIZE-1:0] RamDatenRein,
  input  logic [WORDSIZE-1:0] RamDatenRaus
);

  zustand_t            zustand;
  logic [31:0]         adr_q;
  logic [WORDSIZE-1:0] daten_q;
  logic                schreiben_q;

  logic ist_io;
  logic ist_ram;
  logic ausserhalb;

  speicher_dekoder #(
    .AW(AW)
  ) u_dekoder (
    .adresse   (adr_q),
    .ist_io    (ist_io),
    .ist_ram   (ist_ram),
    .ausserhalb(ausserhalb)
  );

  // Reset gates the write strobe so an interrupted store never reaches the RAM.
  assign RamSchreibenAn = (zustand == ZUGRIFF) && schreiben_q && ist_ram && !ausserhalb && !Reset;
  assign RamAdresse     = adr_q[AW-1:0];
  assign RamDatenRein   = daten_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      zustand     <= LEER;
      Bereit      <= 1'b1;
      Fertig      <= 1'b0;
      DatenRaus   <= '0;
      Ausgabe     <= '0;
      adr_q       <= '0;
      daten_q     <= '0;
      schreiben_q <= 1'b0;
    end else begin
      Fertig <= 1'b0;
      case (zustand)
        LEER: begin
          if (Anfrage) begin
            adr_q       <= Adresse;
            daten_q     <= DatenRein;
            schreiben_q <= SchreibenAn;
            zustand     <= ZUGRIFF;
            Bereit      <= 1'b0;
          end
        end
        ZUGRIFF: begin
          if (ist_io) begin
            if (schreiben_q) begin
              Ausgabe <= daten_q;
            end else begin
              DatenRaus <= Ausgabe;
            end
          end
          // RAM read data arrives one cycle later, so loads take the extra WARTEN step.
          if (ist_ram && !schreiben_q) begin
            zustand <= WARTEN;
          end else begin
            zustand <= FERTIG;
          end
        end
        WARTEN: begin
          DatenRaus <= ausserhalb ? '0 : RamDatenRaus;
          zustand   <= FERTIG;
        end
        FERTIG: begin
          Fertig  <= 1'b1;
          Bereit  <= 1'b1;
          zustand <= LEER;
        end
        default: begin
          Bereit  <= 1'b1;
          zustand <= LEER;
        end
      endcase
    end
  end

`ifdef BEREICHSPRUEFUNG_EN
  logic fehler_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      fehler_q <= 1'b0;
    end else if (zustand == ZUGRIFF && ausserhalb) begin
      fehler_q <= 1'b1;
    end
  end

  assign Fehler = fehler_q;
`else
  assign Fehler = 1'b0;
`endif

endmodule

// File: tb/tb_speicher_steuerung.sv
// tb/tb_speicher_steuerung.sv - self-checking bench for speicher_steuerung with an external RAM model
module tb_speicher_steuerung;

  localparam int WORDS = 256;
  localparam int AW    = 8;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Anfrage;
  logic          SchreibenAn;
  logic [31:0]   Adresse;
  logic [31:0]   DatenRein;
  logic          Bereit;
  logic          Fertig;
  logic [31:0]   DatenRaus;
  logic [31:0]   Ausgabe;
  logic          Fehler;
  logic          RamSchreibenAn;
  logic [AW-1:0] RamAdresse;
  logic [31:0]   RamDatenRein;
  logic [31:0]   RamDatenRaus;

  logic          ram_clear;
  logic [31:0]   ram [0:WORDS-1];

  speicher_steuerung #(
    .WORDSIZE(32),
    .WORDS   (WORDS)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .Anfrage       (Anfrage),
    .SchreibenAn   (SchreibenAn),
    .Adresse       (Adresse),
    .DatenRein     (DatenRein),
    .Bereit        (Bereit),
    .Fertig        (Fertig),
    .DatenRaus     (DatenRaus),
    .Ausgabe       (Ausgabe),
    .Fehler        (Fehler),
    .RamSchreibenAn(RamSchreibenAn),
    .RamAdresse    (RamAdresse),
    .RamDatenRein  (RamDatenRein),
    .RamDatenRaus  (RamDatenRaus)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (ram_clear) begin
      for (int i = 0; i < WORDS; i++) ram[i] <= '0;
    end else begin
      if (RamSchreibenAn) ram[RamAdresse] <= RamDatenRein;
      RamDatenRaus <= ram[RamAdresse];
    end
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [0:WORDS-1];
  logic [31:0] aus_m;
  logic [31:0] dr_m;
  logic        fehler_m;

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_dr;
  } vec_t;

  vec_t tab [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_oor(input logic [31:0] a);
`ifdef BEREICHSPRUEFUNG_EN
    return !a[31] && (((a & 32'h7FFF_FFFF) / WORDS) != 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_access(input bit w, input logic [31:0] a, input logic [31:0] d);
    int idx;
    idx = int'(a % WORDS);
    if (is_oor(a)) fehler_m = 1'b1;
    if (w) begin
      if (a[31]) aus_m = d;
      else if (!is_oor(a)) mem_m[idx] = d;
    end else begin
      if (a[31]) dr_m = aus_m;
      else if (is_oor(a)) dr_m = '0;
      else dr_m = mem_m[idx];
    end
  endtask

  task automatic model_reset();
    aus_m    = '0;
    dr_m     = '0;
    fehler_m = 1'b0;
  endtask

  task automatic do_reset();
    Reset   = 1'b1;
    Anfrage = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic req(input bit w, input logic [31:0] a, input logic [31:0] d);
    int n;
    int we_cnt;
    int lat;
    bit io;
    io  = a[31];
    lat = (!io && !w) ? 3 : 2;
    n   = 0;
    while (!Bereit && n < 10) begin
      @(posedge Clock);
      #1;
      n++;
    end
    check("bereit_wait", (n < 10) ? 32'd1 : 32'd0, 32'd1);
    Anfrage     = 1'b1;
    SchreibenAn = w;
    Adresse     = a;
    DatenRein   = d;
    @(posedge Clock);
    #1;
    Anfrage     = 1'b0;
    SchreibenAn = $urandom_range(0, 1);
    Adresse     = $urandom;
    DatenRein   = $urandom;
    check("bereit_busy", Bereit, 0);
    we_cnt = RamSchreibenAn ? 1 : 0;
    n = 0;
    while (!Fertig && n < 8) begin
      @(posedge Clock);
      #1;
      n++;
      if (RamSchreibenAn) we_cnt++;
      if (n == 1 && io && w) check("ausgabe_zugriff", Ausgabe, d);
    end
    model_access(w, a, d);
    check("latenz", n, lat);
    check("ram_we_count", we_cnt, (w && !io && !is_oor(a)) ? 1 : 0);
    check("datenraus", DatenRaus, dr_m);
    check("ausgabe", Ausgabe, aus_m);
    check("fehler", Fehler, fehler_m);
    @(posedge Clock);
    #1;
    check("fertig_einzeln", Fertig, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, fert, bz, r;
    logic [31:0] a;

    tab[0] = '{1'b1, 32'd5,          32'h0000_00AB, 32'h0000_0000};
    tab[1] = '{1'b0, 32'd5,          32'h0,         32'h0000_00AB};
    tab[2] = '{1'b1, 32'h8000_0000,  32'h0000_0007, 32'h0000_00AB};
    tab[3] = '{1'b0, 32'h8000_0000,  32'h0,         32'h0000_0007};
    tab[4] = '{1'b1, 32'h8000_0010,  32'h0000_0099, 32'h0000_0007};
    tab[5] = '{1'b0, 32'h8000_0004,  32'h0,         32'h0000_0099};
    tab[6] = '{1'b0, 32'd6,          32'h0,         32'h0000_0000};

    for (int i = 0; i < WORDS; i++) mem_m[i] = '0;
    model_reset();
    Reset       = 1'b1;
    ram_clear   = 1'b1;
    Anfrage     = 1'b0;
    SchreibenAn = 1'b0;
    Adresse     = '0;
    DatenRein   = '0;
    repeat (3) @(posedge Clock);
    #1;
    Reset     = 1'b0;
    ram_clear = 1'b0;

    check("reset_bereit", Bereit, 1);
    check("reset_fertig", Fertig, 0);
    check("reset_datenraus", DatenRaus, 0);
    check("reset_ausgabe", Ausgabe, 0);
    check("reset_fehler", Fehler, 0);
    check("reset_ram_we", RamSchreibenAn, 0);

    for (int i = 0; i < 7; i++) begin
      req(tab[i].w, tab[i].a, tab[i].d);
      check("tabelle_datenraus", DatenRaus, tab[i].exp_dr);
    end

    // Anfrage held high, stores alternating between RAM and IO
    acc = 0; fert = 0; bz = 0;
    Anfrage = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (Bereit) begin
        acc++;
        SchreibenAn = 1'b1;
        Adresse     = (acc % 2 == 1) ? 32'd20 : 32'h8000_0000;
        DatenRein   = $urandom;
        model_access(1'b1, Adresse, DatenRein);
      end else begin
        bz++;
      end
      @(posedge Clock);
      #1;
      if (Fertig) fert++;
    end
    Anfrage = 1'b0;
    repeat (4) begin
      @(posedge Clock);
      #1;
      if (Fertig) fert++;
    end
    check("busy_accepts", acc, 10);
    check("busy_bereit_low", bz, 20);
    check("busy_fertig", fert, 10);
    check("busy_ausgabe", Ausgabe, aus_m);
    req(1'b0, 32'd20, 32'h0);

    // reset during ZUGRIFF of a RAM store
    req(1'b1, 32'd3, 32'h5555_0003);
    req(1'b1, 32'h8000_0000, 32'h0000_003C);
    Anfrage     = 1'b1;
    SchreibenAn = 1'b1;
    Adresse     = 32'd3;
    DatenRein   = 32'hFFFF_FFFF;
    @(posedge Clock);
    #1;
    Anfrage = 1'b0;
    Reset   = 1'b1;
    #1;
    check("reset_zugriff_we", RamSchreibenAn, 0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    model_reset();
    fert = 0;
    repeat (5) begin
      @(posedge Clock);
      #1;
      if (Fertig) fert++;
    end
    check("reset_kein_fertig", fert, 0);
    check("reset_ausgabe_null", Ausgabe, 0);
    check("reset_ram3", ram[3], 32'h5555_0003);
    req(1'b0, 32'd3, 32'h0);
    check("reset_load3", DatenRaus, 32'h5555_0003);

    // out-of-range region access
    req(1'b1, 32'd0, 32'h0000_CAFE);
    req(1'b1, 32'h0000_0100, 32'h0000_1234);
`ifdef BEREICHSPRUEFUNG_EN
    check("oor_ram0", ram[0], 32'h0000_CAFE);
    check("oor_fehler", Fehler, 1);
    req(1'b0, 32'h0000_0100, 32'h0);
    check("oor_load", DatenRaus, 32'h0);
`else
    check("alias_ram0", ram[0], 32'h0000_1234);
    check("alias_fehler", Fehler, 0);
    req(1'b0, 32'h0000_0100, 32'h0);
    check("alias_load", DatenRaus, 32'h0000_1234);
`endif
    do_reset();
    check("fehler_nach_reset", Fehler, 0);

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 3);
      case (r)
        0, 1:    a = 32'($urandom_range(0, WORDS - 1));
        2:       a = 32'h8000_0000 | 32'($urandom);
        default: a = 32'($urandom) & 32'h7FFF_FFFF;
      endcase
      req(1'($urandom_range(0, 1)), a, 32'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/speicher_steuerung.md
SPEICHER_STEUERUNG -- requirements
Module: speicher_steuerung

Interface
REQ-001 Parameter WORDSIZE, default 32, SHALL set the data width of CPU and RAM ports.
REQ-002 Parameter WORDS, default 256, SHALL set the RAM depth; AW = $clog2(WORDS).
REQ-003 Clock  input  1  SHALL be the single clock; all state changes on posedge.
REQ-004 Reset  input  1  SHALL be synchronous, active-high.
REQ-005 Anfrage  input  1  SHALL mean the CPU requests an access.
REQ-006 SchreibenAn  input  1  SHALL mean 1 = store, 0 = load.
REQ-007 Adresse  input  32  SHALL be the CPU word address.
REQ-008 DatenRein  input  WORDSIZE  SHALL be the store data.
REQ-009 Bereit  output  1  SHALL mean a request can be accepted this cycle.
REQ-010 Fertig  output  1  SHALL be a one-cycle completion pulse.
REQ-011 DatenRaus  output  WORDSIZE  SHALL be the load result, held until the next load completes.
REQ-012 Ausgabe  output  WORDSIZE  SHALL be the memory-mapped output register.
REQ-013 Fehler  output  1  SHALL be a sticky out-of-range flag.
REQ-014 RamSchreibenAn, RamAdresse[AW-1:0], RamDatenRein[WORDSIZE-1:0]  outputs SHALL drive the RAM write enable, address and write data.
REQ-015 RamDatenRaus  input  WORDSIZE  SHALL be the RAM read data, valid one cycle after the RAM samples a read.

Function
REQ-016 The FSM SHALL have states LEER, ZUGRIFF, WARTEN and FERTIG.
REQ-017 Bereit SHALL be 1 only in LEER; a request SHALL be accepted on the edge where Anfrage=1 and Bereit=1, latching Adresse, DatenRein and SchreibenAn.
REQ-018 Anfrage in any other state SHALL be ignored; the CPU holds it until Bereit=1.
REQ-019 Decode: Adresse[31]=1 SHALL select IO; Adresse[31]=0 SHALL select RAM; RamAdresse = latched Adresse[AW-1:0].
REQ-020 LEER SHALL move to ZUGRIFF on accept.
REQ-021 In ZUGRIFF, RAM drive: RamSchreibenAn=1 for a RAM store, else 0; RamAdresse and RamDatenRein SHALL be driven from the latched values.
REQ-022 In every other state, RamSchreibenAn SHALL be 0.
REQ-023 ZUGRIFF SHALL go to WARTEN for a RAM load, and to FERTIG otherwise.
REQ-024 WARTEN SHALL capture RamDatenRaus into DatenRaus and go to FERTIG.
REQ-025 An IO store SHALL load Ausgabe on the ZUGRIFF edge; an IO load SHALL return Ausgabe into DatenRaus on that edge.
REQ-026 In FERTIG, Fertig SHALL be 1 for exactly one cycle, then the FSM SHALL return to LEER.
REQ-027 Latency from accept edge to Fertig=1 SHALL be:
  - RAM load: 3 cycles.
  - Store or IO load: 2 cycles.
REQ-028 Back-to-back requests SHALL be possible at one request per 3 cycles (stores, IO) or 4 cycles (RAM loads).

Reset
REQ-029 Reset=1 SHALL force, on that edge: state LEER, Fertig=0, DatenRaus=0, Ausgabe=0, Fehler=0.
REQ-030 RamSchreibenAn SHALL be gated with !Reset, so a reset during ZUGRIFF writes nothing; RAM contents are not cleared.
REQ-031 A request in flight at reset SHALL be dropped with no Fertig pulse.

Configuration
REQ-032 Macro BEREICHSPRUEFUNG_EN, when defined, SHALL treat a RAM-region access with Adresse[30:AW]≠0 as out of range:
  - stores suppressed (no RAM write);
  - loads return 0;
  - Fehler set to 1 until Reset;
  - Fertig still pulses with normal latency.
REQ-033 Without BEREICHSPRUEFUNG_EN, upper address bits SHALL be ignored (aliasing) and Fehler SHALL be tied to 0.

Structure
REQ-034 Shared package speicher_pkg SHALL hold:
  - the FSM state typedef;
  - IO_BIT=31;
  - default WORDSIZE and WORDS constants.
REQ-035 The address decode (IO / RAM / out-of-range) SHALL be the combinational sub-module speicher_dekoder.
REQ-036 The RAM SHALL be instantiated beside this block, not inside it.

Verification
REQ-037 Store then load: store 0x0000_00AB to address 5, then load address 5 -> Fertig 2 cycles after the store accept; DatenRaus=0x0000_00AB 3 cycles after the load accept.
REQ-038 IO access: store 0x0000_0007 to address 0x8000_0000 -> Ausgabe=0x7 on the ZUGRIFF edge; load from 0x8000_0000 -> DatenRaus=0x7, RamSchreibenAn never 1.
REQ-039 Busy handling: Anfrage held high continuously with alternating stores -> Bereit=0 in ZUGRIFF, WARTEN and FERTIG; exactly one accept per Bereit=1 cycle; no lost or duplicated Fertig.
REQ-040 Reset mid-store: assert Reset during ZUGRIFF of a store of 0xFFFF_FFFF to address 3 -> a later load of address 3 returns the prior value; no Fertig pulse; Ausgabe=0.
REQ-041 Out of range with macro: store 0x1234 to address 0x0000_0100 (WORDS=256) -> RAM word 0 unchanged, Fehler=1; a following load returns 0.
REQ-042 Out of range without macro: same stimulus -> RAM word 0 = 0x1234, Fehler=0.
